snake_frame_scanner: RTL and testbench

- Reader side of the snake body store. Each game tick it walks BODY_POS from head to LENGTH-1 and rasterises the snake plus the item into a 16x16 draw buffer.
- On completion it swaps the draw buffer into a display buffer.
- Independently, it scans the display buffer row by row to drive a 16x16 LED matrix.
- Runs on SYS_CLK; CLK, the game tick from the game clock, is treated as a synchronous level that is sampled and edge-detected.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_row_scanner.sv | 51 +++++
 rtl/snake_frame_scanner.sv | 126 ++++++++++++
 tb/tb_snake_frame_scanner.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and sizes for the snake frame scanner.
package snake_pkg;

    localparam int unsigned GRID_W  = 16;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned MAX_SEG = 256;
    localparam int unsigned LEN_W   = 8;

    typedef logic [COORD_W-1:0] coord_t;

    // Body segment / cell coordinate, packed as {y, x}.
    typedef struct packed {
        coord_t y;
        coord_t x;
    } pos_t;

    typedef logic [GRID_W-1:0] row_t;

    // Whole 16x16 picture; index is the row, bit within a row is the column.
    typedef row_t [GRID_W-1:0] frame_t;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWalk,
        StItem,
        StSwap
    } state_e;

endpackage

// File: rtl/snake_row_scanner.sv
// LED matrix row scanner: holds each row for ROW_DWELL cycles, toggles the
// blink phase once per full scan and registers the column pixels of the row.
module snake_row_scanner
    import snake_pkg::*;
#(
    parameter int unsigned ROW_DWELL = 1000
) (
    input  logic   sys_clk,
    input  logic   rst_n,
    input  frame_t disp,
    input  logic   collision,
    output coord_t row_sel,
    output row_t   col_data
);

    localparam int unsigned CNT_W = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(ROW_DWELL - 1);

    logic [CNT_W-1:0] dwell_q;
    logic             blink_q;
    logic             row_wrap;

    assign row_wrap = (dwell_q == DWELL_LAST);

    // Dwell counter, row pointer and blink phase (toggles on the 15 -> 0 wrap).
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            row_sel <= '0;
            blink_q <= 1'b0;
        end else if (row_wrap) begin
            dwell_q <= '0;
            row_sel <= row_sel + 1'b1;
            if (row_sel == coord_t'(GRID_W - 1)) begin
                blink_q <= ~blink_q;
            end
        end else begin
            dwell_q <= dwell_q + 1'b1;
        end
    end

    // Column data follows row_sel by one cycle; blink inverts only during a collision.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_data <= '0;
        end else begin
            col_data <= disp[row_sel] ^ {GRID_W{collision & blink_q}};
        end
    end

endmodule

// File: rtl/snake_frame_scanner.sv
// Snake body rasteriser: on each game tick walks the body list into a draw
// buffer, adds the item, swaps it into the display buffer and scans it out.
module snake_frame_scanner
    import snake_pkg::*;
#(
    parameter int unsigned ROW_DWELL = 1000
) (
    input  logic                    SYS_CLK,
    input  logic                    RST,
    input  logic                    CLK,
    input  pos_t [MAX_SEG-1:0]      BODY_POS,
    input  logic [LEN_W-1:0]        LENGTH,
    input  logic [COORD_W-1:0]      ITEM_X,
    input  logic [COORD_W-1:0]      ITEM_Y,
    input  logic                    ITEM_VALID,
    input  logic                    COLLISION,
    output logic [COORD_W-1:0]      ROW_SEL,
    output logic [GRID_W-1:0]       COL_DATA,
    output logic                    FRAME_DONE,
    output logic                    BUSY
);

    state_e             state_q;
    logic               clk_d_q;
    logic               pending_q;
    logic               busy_q;
    logic               frame_done_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    frame_t             draw_q;
    frame_t             disp_q;
    logic               tick;
    pos_t               seg;

    // The game tick is a level from another domain's logic; only its rising edge matters.
    assign tick = CLK & ~clk_d_q;
    assign seg  = BODY_POS[idx_q];

    assign BUSY       = busy_q;
    assign FRAME_DONE = frame_done_q;

    // Previous game-tick level for edge detection.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            clk_d_q <= 1'b0;
        end else begin
            clk_d_q <= CLK;
        end
    end

    // Frame FSM: clear, walk body, draw item, swap buffers; one pending frame is queued.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            len_q        <= '0;
            idx_q        <= '0;
            draw_q       <= '0;
            disp_q       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            // Any number of ticks during a frame collapse into one pending request.
            if (tick && (state_q != StIdle)) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q <= StClear;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    draw_q  <= '0;
                    len_q   <= LENGTH;
                    idx_q   <= '0;
                    state_q <= (LENGTH != '0) ? StWalk : StItem;
                end
                StWalk: begin
                    draw_q[seg.y][seg.x] <= 1'b1;
                    idx_q                <= idx_q + 1'b1;
                    if (idx_q == (len_q - 8'd1)) begin
                        state_q <= StItem;
                    end
                end
                StItem: begin
                    if (ITEM_VALID) begin
                        draw_q[ITEM_Y][ITEM_X] <= 1'b1;
                    end
                    state_q <= StSwap;
                end
                StSwap: begin
                    disp_q       <= draw_q;
                    frame_done_q <= 1'b1;
                    // A tick landing on the swap cycle is served straight away.
                    pending_q    <= 1'b0;
                    if (pending_q || tick) begin
                        state_q <= StClear;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    busy_q    <= 1'b0;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    snake_row_scanner #(
        .ROW_DWELL (ROW_DWELL)
    ) u_row_scanner (
        .sys_clk   (SYS_CLK),
        .rst_n     (RST),
        .disp      (disp_q),
        .collision (COLLISION),
        .row_sel   (ROW_SEL),
        .col_data  (COL_DATA)
    );

endmodule

// File: tb/tb_snake_frame_scanner.sv
// Bench for snake_frame_scanner: frame scoreboard plus row-scan timing model.
module tb_snake_frame_scanner;
    import snake_pkg::*;

    localparam int unsigned DWELL = 4;

    logic               SYS_CLK = 1'b0;
    logic               RST = 1'b1;
    logic               CLK = 1'b0;
    pos_t [MAX_SEG-1:0] BODY_POS = '0;
    logic [7:0]         LENGTH = '0;
    coord_t             ITEM_X = '0;
    coord_t             ITEM_Y = '0;
    logic               ITEM_VALID = 1'b0;
    logic               COLLISION = 1'b0;
    coord_t             ROW_SEL;
    row_t               COL_DATA;
    logic               FRAME_DONE;
    logic               BUSY;

    int                 checks = 0;
    int                 errors = 0;
    int unsigned        cyc = 0;
    int unsigned        n_run = 0;
    int unsigned        busy_cnt = 0;
    int unsigned        done_cnt = 0;
    frame_t             exp_frame_q[$];
    frame_t             obs_frame_q[$];
    int unsigned        exp_cyc_q[$];
    int unsigned        obs_cyc_q[$];
    frame_t             model_disp = '0;

    snake_frame_scanner #(
        .ROW_DWELL (DWELL)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .CLK        (CLK),
        .BODY_POS   (BODY_POS),
        .LENGTH     (LENGTH),
        .ITEM_X     (ITEM_X),
        .ITEM_Y     (ITEM_Y),
        .ITEM_VALID (ITEM_VALID),
        .COLLISION  (COLLISION),
        .ROW_SEL    (ROW_SEL),
        .COL_DATA   (COL_DATA),
        .FRAME_DONE (FRAME_DONE),
        .BUSY       (BUSY)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    always @(posedge SYS_CLK) cyc <= cyc + 1;

    // Clock edges seen since reset release; drives the scan timing model.
    always @(posedge SYS_CLK or negedge RST) begin
        if (!RST) n_run <= 0;
        else      n_run <= n_run + 1;
    end

    always @(negedge SYS_CLK) begin
        busy_cnt <= busy_cnt + {31'd0, BUSY};
        done_cnt <= done_cnt + {31'd0, FRAME_DONE};
    end

    function automatic frame_t raster(input int len, input pos_t [MAX_SEG-1:0] body,
                                      input coord_t ix, input coord_t iy, input logic iv);
        frame_t f;
        f = '0;
        for (int i = 0; i < len; i++) f[body[i].y][body[i].x] = 1'b1;
        if (iv) f[iy][ix] = 1'b1;
        return f;
    endfunction

    // Raises the game tick for one cycle; on return cyc equals the edge that sees it.
    task automatic pulse_tick();
        @(negedge SYS_CLK);
        CLK = 1'b1;
        @(negedge SYS_CLK);
        CLK = 1'b0;
    endtask

    task automatic collect_frames(input int n, input int budget, output int got);
        got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            @(negedge SYS_CLK);
            if (FRAME_DONE === 1'b1) begin
                got++;
                obs_cyc_q.push_back(cyc);
                obs_frame_q.push_back(dut.disp_q);
            end
        end
    endtask

    task automatic clear_queues();
        exp_frame_q.delete();
        obs_frame_q.delete();
        exp_cyc_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic test_reset();
        #2 RST = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        checks++; if (ROW_SEL !== 4'h0) begin errors++; $display("FAIL reset_row_sel: got %0h expected 0", ROW_SEL); end
        checks++; if (COL_DATA !== 16'h0) begin errors++; $display("FAIL reset_col_data: got %0h expected 0", COL_DATA); end
        checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b expected 0", FRAME_DONE); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", BUSY); end
        checks++; if (dut.disp_q !== '0) begin errors++; $display("FAIL reset_disp: got %0h expected 0", dut.disp_q); end
        RST = 1'b1;
    endtask

    task automatic test_directed();
        int unsigned k, ec, oc;
        int got;
        frame_t ef, of;
        clear_queues();
        BODY_POS = '0;
        BODY_POS[0] = 8'h55;
        BODY_POS[1] = 8'h54;
        BODY_POS[2] = 8'h53;
        LENGTH = 8'd3;
        ITEM_X = 4'd2;
        ITEM_Y = 4'd9;
        ITEM_VALID = 1'b1;
        pulse_tick();
        k = cyc;
        ef = '0;
        ef[5] = 16'h0038;
        ef[9] = 16'h0004;
        exp_cyc_q.push_back(k + 6);
        exp_frame_q.push_back(ef);
        collect_frames(1, 40, got);
        checks++; if (got !== 1) begin errors++; $display("FAIL directed_count: got %0d frames expected 1", got); end
        while (obs_cyc_q.size() > 0 && exp_cyc_q.size() > 0) begin
            ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
            ef = exp_frame_q.pop_front(); of = obs_frame_q.pop_front();
            checks++; if (oc !== ec) begin errors++; $display("FAIL directed_latency: done at cycle %0d expected %0d", oc, ec); end
            checks++; if (of !== ef) begin errors++; $display("FAIL directed_disp: got %0h expected %0h", of, ef); end
            model_disp = ef;
        end
        @(negedge SYS_CLK);
        checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL directed_pulse_width: FRAME_DONE=%0b expected 0", FRAME_DONE); end
    endtask

    task automatic test_empty();
        int unsigned k, ec, oc, b0;
        int got;
        frame_t ef, of;
        clear_queues();
        LENGTH = 8'd0;
        ITEM_VALID = 1'b0;
        #1 b0 = busy_cnt;
        pulse_tick();
        k = cyc;
        exp_cyc_q.push_back(k + 3);
        exp_frame_q.push_back('0);
        collect_frames(1, 20, got);
        repeat (3) @(negedge SYS_CLK);
        #1;
        checks++; if (got !== 1) begin errors++; $display("FAIL empty_count: got %0d frames expected 1", got); end
        while (obs_cyc_q.size() > 0 && exp_cyc_q.size() > 0) begin
            ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
            ef = exp_frame_q.pop_front(); of = obs_frame_q.pop_front();
            checks++; if (oc !== ec) begin errors++; $display("FAIL empty_latency: done at cycle %0d expected %0d", oc, ec); end
            checks++; if (of !== ef) begin errors++; $display("FAIL empty_disp: got %0h expected %0h", of, ef); end
            model_disp = ef;
        end
        checks++; if (busy_cnt - b0 !== 3) begin errors++; $display("FAIL empty_busy_cycles: got %0d expected 3", busy_cnt - b0); end
    endtask

    task automatic test_back_to_back();
        int unsigned k, ec, oc, b0, d0;
        int got;
        frame_t ef, of;
        clear_queues();
        for (int i = 0; i < MAX_SEG; i++) BODY_POS[i] = pos_t'(8'($urandom));
        LENGTH = 8'd200;
        ITEM_X = 4'd11;
        ITEM_Y = 4'd3;
        ITEM_VALID = 1'b1;
        #1 b0 = busy_cnt; d0 = done_cnt;
        pulse_tick();
        k = cyc;
        ef = raster(200, BODY_POS, ITEM_X, ITEM_Y, ITEM_VALID);
        exp_cyc_q.push_back(k + 203);
        exp_frame_q.push_back(ef);
        exp_cyc_q.push_back(k + 406);
        exp_frame_q.push_back(ef);
        repeat (10) @(negedge SYS_CLK);
        pulse_tick();
        repeat (20) @(negedge SYS_CLK);
        pulse_tick();
        collect_frames(2, 600, got);
        repeat (3) @(negedge SYS_CLK);
        #1;
        checks++; if (got !== 2) begin errors++; $display("FAIL busy_count: got %0d frames expected 2", got); end
        while (obs_cyc_q.size() > 0 && exp_cyc_q.size() > 0) begin
            ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
            ef = exp_frame_q.pop_front(); of = obs_frame_q.pop_front();
            checks++; if (oc !== ec) begin errors++; $display("FAIL busy_latency: done at cycle %0d expected %0d", oc, ec); end
            checks++; if (of !== ef) begin errors++; $display("FAIL busy_disp: got %0h expected %0h", of, ef); end
            model_disp = ef;
        end
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL busy_pulses: got %0d expected 2", done_cnt - d0); end
        checks++; if (busy_cnt - b0 !== 406) begin errors++; $display("FAIL busy_cycles: got %0d expected 406", busy_cnt - b0); end
    endtask

    task automatic test_scan();
        int unsigned k, ec, oc;
        int got, wraps;
        frame_t ef, of;
        coord_t prev_row;
        row_t pend[$];
        row_t e;
        logic blink_e;
        clear_queues();
        COLLISION = 1'b0;
        for (int i = 0; i < 16; i++) BODY_POS[i] = pos_t'({4'(i), 4'(i)});
        LENGTH = 8'd16;
        ITEM_X = 4'd0;
        ITEM_Y = 4'd15;
        ITEM_VALID = 1'b1;
        pulse_tick();
        k = cyc;
        for (int r = 0; r < 16; r++) ef[r] = 16'd1 << r;
        ef[15] = ef[15] | 16'h0001;
        exp_cyc_q.push_back(k + 19);
        exp_frame_q.push_back(ef);
        collect_frames(1, 60, got);
        checks++; if (got !== 1) begin errors++; $display("FAIL scan_load_count: got %0d frames expected 1", got); end
        while (obs_cyc_q.size() > 0 && exp_cyc_q.size() > 0) begin
            ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
            ef = exp_frame_q.pop_front(); of = obs_frame_q.pop_front();
            checks++; if (oc !== ec) begin errors++; $display("FAIL scan_load_latency: done at cycle %0d expected %0d", oc, ec); end
            checks++; if (of !== ef) begin errors++; $display("FAIL scan_load_disp: got %0h expected %0h", of, ef); end
            model_disp = ef;
        end
        wraps = 0;
        repeat (2) @(negedge SYS_CLK);
        prev_row = ROW_SEL;
        for (int i = 0; i < 140; i++) begin
            @(negedge SYS_CLK);
            checks++; if (ROW_SEL !== 4'((n_run / DWELL) % 16)) begin errors++; $display("FAIL scan_row: ROW_SEL=%0d expected %0d", ROW_SEL, (n_run / DWELL) % 16); end
            if (pend.size() != 0) begin
                e = pend.pop_front();
                checks++; if (COL_DATA !== e) begin errors++; $display("FAIL scan_col: COL_DATA=%0h expected %0h", COL_DATA, e); end
            end
            if (ROW_SEL != prev_row) begin
                if (prev_row == 4'd15 && ROW_SEL == 4'd0) wraps++;
                blink_e = ((n_run / (DWELL * 16)) % 2) == 1;
                pend.push_back(model_disp[ROW_SEL] ^ {16{COLLISION & blink_e}});
            end
            prev_row = ROW_SEL;
        end
        checks++; if (wraps < 2) begin errors++; $display("FAIL scan_wraps: got %0d expected at least 2", wraps); end
    endtask

    task automatic test_blink();
        int inverted, normal;
        coord_t prev_row;
        row_t pend[$];
        row_t e;
        logic blink_e;
        COLLISION = 1'b1;
        inverted = 0;
        normal = 0;
        @(negedge SYS_CLK);
        prev_row = ROW_SEL;
        for (int i = 0; i < 200; i++) begin
            @(negedge SYS_CLK);
            if (pend.size() != 0) begin
                e = pend.pop_front();
                checks++; if (COL_DATA !== e) begin errors++; $display("FAIL blink_col: COL_DATA=%0h expected %0h", COL_DATA, e); end
                if (COL_DATA === ~model_disp[prev_row]) inverted++;
                if (COL_DATA === model_disp[prev_row]) normal++;
            end
            if (ROW_SEL != prev_row) begin
                blink_e = ((n_run / (DWELL * 16)) % 2) == 1;
                pend.push_back(model_disp[ROW_SEL] ^ {16{COLLISION & blink_e}});
            end
            prev_row = ROW_SEL;
        end
        checks++; if (inverted < 16 || normal < 16) begin errors++; $display("FAIL blink_phases: inverted rows %0d normal rows %0d expected at least 16 each", inverted, normal); end
        COLLISION = 1'b0;
    endtask

    task automatic test_reset_mid_walk();
        int unsigned k, ec, oc, b0, d0;
        int got;
        frame_t ef, of;
        clear_queues();
        COLLISION = 1'b1;
        for (int i = 0; i < MAX_SEG; i++) BODY_POS[i] = pos_t'(8'($urandom));
        LENGTH = 8'd200;
        pulse_tick();
        repeat (20) @(negedge SYS_CLK);
        pulse_tick();
        repeat (5) @(negedge SYS_CLK);
        @(posedge SYS_CLK);
        #2 RST = 1'b0;
        #1;
        checks++; if (ROW_SEL !== 4'h0) begin errors++; $display("FAIL midreset_row_sel: got %0h expected 0", ROW_SEL); end
        checks++; if (COL_DATA !== 16'h0) begin errors++; $display("FAIL midreset_col_data: got %0h expected 0", COL_DATA); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b expected 0", BUSY); end
        checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL midreset_frame_done: got %0b expected 0", FRAME_DONE); end
        checks++; if (dut.disp_q !== '0) begin errors++; $display("FAIL midreset_disp: got %0h expected 0", dut.disp_q); end
        model_disp = '0;
        COLLISION = 1'b0;
        @(negedge SYS_CLK);
        RST = 1'b1;
        #1 b0 = busy_cnt; d0 = done_cnt;
        repeat (300) @(negedge SYS_CLK);
        #1;
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL midreset_no_frame: got %0d pulses expected 0", done_cnt - d0); end
        checks++; if (busy_cnt - b0 !== 0) begin errors++; $display("FAIL midreset_idle: busy for %0d cycles expected 0", busy_cnt - b0); end
        BODY_POS = '0;
        BODY_POS[0] = 8'hA7;
        BODY_POS[1] = 8'hA8;
        LENGTH = 8'd2;
        ITEM_X = 4'd15;
        ITEM_Y = 4'd0;
        ITEM_VALID = 1'b1;
        pulse_tick();
        k = cyc;
        ef = '0;
        ef[10] = 16'h0180;
        ef[0] = 16'h8000;
        exp_cyc_q.push_back(k + 5);
        exp_frame_q.push_back(ef);
        collect_frames(1, 40, got);
        checks++; if (got !== 1) begin errors++; $display("FAIL midreset_new_count: got %0d frames expected 1", got); end
        while (obs_cyc_q.size() > 0 && exp_cyc_q.size() > 0) begin
            ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
            ef = exp_frame_q.pop_front(); of = obs_frame_q.pop_front();
            checks++; if (oc !== ec) begin errors++; $display("FAIL midreset_new_latency: done at cycle %0d expected %0d", oc, ec); end
            checks++; if (of !== ef) begin errors++; $display("FAIL midreset_new_disp: got %0h expected %0h", of, ef); end
            model_disp = ef;
        end
    endtask

    initial begin
        test_reset();
        repeat (2) @(negedge SYS_CLK);
        test_directed();
        test_empty();
        test_back_to_back();
        test_scan();
        test_blink();
        test_reset_mid_walk();
        repeat (4) @(negedge SYS_CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
